block_mem_responder: RTL and testbench
======================================

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per word.
REQ-002 Parameter ADDR_WIDTH, default 32: byte/word address width on mem_addr.
REQ-003 Parameter BLOCK_SIZE, default 16: words per block; OFFSET_WIDTH = $clog2(BLOCK_SIZE).
REQ-004 Parameter MEM_BLOCKS, default 256, power of two: blocks in backing store; BIDX_WIDTH = $clog2(MEM_BLOCKS).
REQ-005 Parameter LATENCY, default 4, range 1..255: cycles from request accept to mem_ready.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 mem_addr  input  ADDR_WIDTH  block request address from the cache.
REQ-009 mem_data_out  input  BLOCK_SIZE x DATA_WIDTH  write block from the cache.
REQ-010 mem_read  input  1  read request, held by the requester until mem_ready.
REQ-011 mem_write  input  1  write request, held by the requester until mem_ready.
REQ-012 mem_data_block  output  BLOCK_SIZE x DATA_WIDTH  registered response block.
REQ-013 mem_ready  output  1  registered single-cycle completion pulse.
REQ-014 busy  output  1  high while a transaction is accepted and not yet completed.

Function
REQ-015 Block index SHALL be mem_addr[OFFSET_WIDTH+BIDX_WIDTH-1:OFFSET_WIDTH]; offset bits and bits above the index are ignored, so addresses wrap modulo MEM_BLOCKS.
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; encoding is free.
REQ-017 IDLE: when (mem_read|mem_write) is sampled high, latch index, mem_data_out, read and write flags; load the counter with LATENCY-1; go to WAIT (or RESP directly if LATENCY==1).
REQ-018 WAIT: decrement the counter each cycle; on count 0 go to RESP; request inputs are ignored.
REQ-019 RESP: mem_ready=1 for exactly one cycle; next state is IDLE unconditionally.
REQ-020 mem_ready SHALL rise exactly LATENCY cycles after the accepting edge.
REQ-021 Read only: mem_data_block = stored block at the latched index, valid only in the mem_ready cycle.
REQ-022 Write only: the latched block SHALL be written to storage at the RESP edge; mem_data_block = the written block in the mem_ready cycle.
REQ-023 Read and write together SHALL be treated as a write; the response returns the newly written block.
REQ-024 mem_data_block SHALL be zero in every cycle where mem_ready=0.
REQ-025 The requester drops its request in the mem_ready cycle. A request still high in the following IDLE cycle is a new transaction. Back-to-back throughput is one transaction per LATENCY+1 cycles.
REQ-026 Deasserting the request during WAIT SHALL NOT abort the transaction: the write still commits and mem_ready still pulses.
REQ-027 Changes to mem_addr or mem_data_out after acceptance SHALL have no effect on the current transaction.
REQ-028 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.

Reset
REQ-029 On rst_n low: state=IDLE, counter=0, latched request cleared, mem_ready=0, mem_data_block=0, busy=0, all asynchronously.
REQ-030 Storage contents SHALL NOT be reset. Simulation initialises storage to zero.
REQ-031 Reset during WAIT/RESP SHALL abandon the transaction; a pending write is not committed unless its RESP edge has already occurred.

Structure
REQ-032 Shared package cache_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH and BLOCK_SIZE defaults, plus the block typedef (BLOCK_SIZE x DATA_WIDTH). The same typedef is used on the cache side of this interface.
REQ-033 Storage SHALL be one sub-module, block_store_ram: one synchronous write port and one read port, MEM_BLOCKS x block, no reset.
REQ-034 FSM, counter and output registers SHALL reside in block_mem_responder.

Verification
REQ-035 Reset, then read addr 0x0000_0040 (BLOCK_SIZE=16, index 4) -> mem_ready pulses exactly 4 cycles after accept; data all zero; busy high for 4 cycles.
REQ-036 Write block with words 0x1000+i to addr 0x80, then read 0x80 -> the write response echoes the block; the read returns words 0x1000+i.
REQ-037 Write 0xAAAA_AAAA-filled block to index 255, then read the address with index 256 (wraps to 0) and read index 255 -> index 0 is unchanged; index 255 returns 0xAAAA_AAAA.
REQ-038 mem_read and mem_write both high with block 0x5555_5555 -> treated as a write; response is 0x5555_5555; a later read matches.
REQ-039 Drop the request 1 cycle after a write accept; separately, change mem_addr during WAIT -> the write still commits to the original index; mem_ready still pulses.
REQ-040 Assert rst_n low 2 cycles into a write WAIT -> mem_ready never pulses; storage at that index is unchanged; a new request after reset completes normally with LATENCY timing.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache/memory interface defaults, block type and responder states
package cache_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_BLOCK_SIZE = 16;

  // One cache block as seen on both sides of the memory interface
  typedef logic [DEFAULT_BLOCK_SIZE-1:0][DEFAULT_DATA_WIDTH-1:0] block_t;

  // Responder transaction phases
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_e;

endpackage

// File: rtl/block_store_ram.sv
// rtl/block_store_ram.sv - block-wide backing store, one sync write port, one async read port
module block_store_ram #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Contents are deliberately not reset; they survive a responder reset
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Commit a whole block on a write strobe
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/block_mem_responder.sv
// rtl/block_mem_responder.sv - fixed-latency block memory responder for a cache refill/writeback port
module block_mem_responder
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
  parameter int MEM_BLOCKS = 256,
  parameter int LATENCY    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
  input  logic                                  mem_read,
  input  logic                                  mem_write,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
  output logic                                  mem_ready,
  output logic                                  busy
);

  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int BIDX_WIDTH   = $clog2(MEM_BLOCKS);
  localparam int BLOCK_BITS   = BLOCK_SIZE * DATA_WIDTH;

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

  resp_state_e           state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [BIDX_WIDTH-1:0] idx_q, idx_d;
  blk_t                  wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  blk_t                  block_q, block_d;

  blk_t                  ram_rdata;
  logic                  ram_we;
  logic                  unused_addr;

  // Offset bits and bits above the index take no part in addressing
  assign unused_addr = ^mem_addr;

  // The latched block lands in storage on the edge that leaves RESP
  assign ram_we = (state_q == ST_RESP) && wr_q;

  block_store_ram #(
    .WIDTH (BLOCK_BITS),
    .DEPTH (MEM_BLOCKS),
    .AW    (BIDX_WIDTH)
  ) u_store (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (ram_rdata)
  );

  // Next-state: accept in IDLE, count down in WAIT, form the response in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    block_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = mem_addr[OFFSET_WIDTH+BIDX_WIDTH-1:OFFSET_WIDTH];
          wdata_d = mem_data_out;
          rd_d    = mem_read & ~mem_write;
          wr_d    = mem_write;
          cnt_d   = 8'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_d == 8'd0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        // A combined read+write returns the block being written
        if (wr_q) begin
          block_d = wdata_q;
        end else if (rd_q) begin
          block_d = ram_rdata;
        end
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      block_q <= block_d;
    end
  end

  assign mem_ready      = ready_q;
  assign busy           = busy_q;
  assign mem_data_block = block_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// tb/tb_block_mem_responder.sv - directed and randomized checks of block_mem_responder against a memory model
module tb_block_mem_responder;
  import cache_pkg::*;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  block_t      mem_data_out;
  logic        mem_read;
  logic        mem_write;
  block_t      mem_data_block;
  logic        mem_ready;
  logic        busy;

  int n_pass;
  int n_total;

  // Reference memory: one entry per block, starts all zero
  block_t model [256];

  block_mem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .BLOCK_SIZE (16),
    .MEM_BLOCKS (256),
    .LATENCY    (LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_data_out   (mem_data_out),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_data_block (mem_data_block),
    .mem_ready      (mem_ready),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic block_t fill(input logic [31:0] w);
    block_t b;
    for (int i = 0; i < 16; i++) b[i] = w;
    return b;
  endfunction

  function automatic block_t rand_block();
    block_t b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction

  function automatic int index_of(input logic [31:0] addr);
    return int'((addr / 32'd16) % 32'd256);
  endfunction

  // One transaction; mode 0 holds the request, 1 drops it one cycle after
  // accept, 2 scrambles address and write data during the wait
  task automatic txn(input string tag, input bit rd, input bit wr,
                     input logic [31:0] addr, input block_t blk, input int mode);
    block_t expv;
    int     idx;
    int     k;
    bit     seen;
    idx          = index_of(addr);
    mem_read     = rd;
    mem_write    = wr;
    mem_addr     = addr;
    mem_data_out = blk;
    @(posedge clk);
    if (wr) begin
      model[idx] = blk;
      expv       = blk;
    end else begin
      expv = model[idx];
    end
    @(negedge clk);
    check({tag, "/busy_accept"}, busy, 1);
    if (mode == 1) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end else if (mode == 2) begin
      mem_addr     = addr ^ 32'h0000_0550;
      mem_data_out = rand_block();
    end
    seen = 1'b0;
    for (k = 1; k <= LAT + 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check({tag, "/busy_wait"}, busy, 1);
      check({tag, "/zero_wait"}, mem_data_block, '0);
    end
    check({tag, "/latency"}, k, LAT);
    check({tag, "/seen_ready"}, seen, 1);
    check({tag, "/data"}, mem_data_block, expv);
    check({tag, "/busy_ready"}, busy, 0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "/ready_pulse"}, mem_ready, 0);
    check({tag, "/zero_after"}, mem_data_block, '0);
  endtask

  initial begin
    block_t b;
    logic [31:0] a;
    int op;
    n_pass       = 0;
    n_total      = 0;
    rst_n        = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = '0;

    repeat (3) @(negedge clk);
    check("reset/mem_ready", mem_ready, 0);
    check("reset/busy", busy, 0);
    check("reset/data", mem_data_block, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unwritten block reads as zero
    txn("read40", 1, 0, 32'h0000_0040, '0, 0);

    // Write then read back an incrementing block
    for (int i = 0; i < 16; i++) b[i] = 32'h1000 + i;
    txn("write80", 0, 1, 32'h0000_0080, b, 0);
    txn("read80", 1, 0, 32'h0000_0080, '0, 0);

    // Highest index, then wrap of index 256 back to 0
    txn("write255", 0, 1, 32'h0000_0FF0, fill(32'hAAAA_AAAA), 0);
    txn("read256", 1, 0, 32'h0000_1000, '0, 0);
    txn("read255", 1, 0, 32'h0000_0FF0, '0, 0);

    // Read and write together behave as a write
    txn("rdwr", 1, 1, 32'h0000_0140, fill(32'h5555_5555), 0);
    txn("rdwr_back", 1, 0, 32'h0000_0140, '0, 0);

    // Request dropped early, and address changed mid-wait
    txn("drop", 0, 1, 32'h0000_0200, fill(32'h0D0D_0D0D), 1);
    txn("drop_back", 1, 0, 32'h0000_0200, '0, 0);
    txn("addrchg", 0, 1, 32'h0000_0240, fill(32'hC4C4_C4C4), 2);
    txn("addrchg_back", 1, 0, 32'h0000_0240, '0, 0);
    txn("addrchg_other", 1, 0, 32'h0000_0240 ^ 32'h0000_0550, '0, 0);

    // Reset two cycles into a write wait abandons it
    txn("pre7", 0, 1, 32'h0000_0070, fill(32'h7777_7777), 0);
    mem_write    = 1'b1;
    mem_addr     = 32'h0000_0070;
    mem_data_out = fill(32'hDEAD_BEEF);
    @(posedge clk);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstwait/busy", busy, 0);
    check("rstwait/ready", mem_ready, 0);
    mem_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstwait/no_ready", mem_ready, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    txn("rst_back7", 1, 0, 32'h0000_0070, '0, 0);

    // Randomized traffic over a small index pool plus the top indices
    for (int t = 0; t < 30; t++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom & ~32'h0000_0FF0) | (32'($urandom_range(0, 7)) << 4);
      if ($urandom_range(0, 3) == 0) a = a | 32'h0000_0F80;
      b  = rand_block();
      txn("rand", op != 1, op != 0, a, b, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
